rn_fc_ctrl: RTL and testbench

- Consumer/sequencer side of the FC parameter-structure interface.
- Drives the structure's next_layer / next_neuron / get_weight requests and waits on its struct_ready.
- Reads activations from the input feature buffer and runs an INPUTS_MAC-lane signed MAC per weight group.
- Requantizes each neuron's sum and writes it to the output feature buffer at of_offset + neuron index.

---
 rtl/rn_fc_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_rn_fc_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rn_fc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rn_fc_ctrl
// Brief    : FC layer sequencer: requests parameters, runs a multi-lane signed
//            MAC per weight group and writes requantized neuron outputs.
// Revision : 1.0 - initial release
// ============================================================================
module rn_fc_ctrl #(
    parameter int INPUTS_MAC = 6,
    parameter int SHIFT      = 0,
    parameter int ACC_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              cant_inputs,
    input  logic [15:0]             iters_per_neuron,
    input  logic [7:0]              modulo,
    input  logic [7:0]              cant_neurons,
    input  logic [7:0]              last,
    input  logic [15:0]             of_offset,
    input  logic [INPUTS_MAC*8-1:0] kernel_FC,
    input  logic [7:0]              bias_FC,
    input  logic                    struct_ready,
    output logic                    next_layer,
    output logic                    next_neuron,
    output logic                    get_weight,
    output logic                    act_rd,
    output logic [15:0]             act_addr,
    input  logic [INPUTS_MAC*8-1:0] act_data,
    output logic                    of_wr,
    output logic [15:0]             of_addr,
    output logic [7:0]              of_data,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_err
);

    localparam logic [3:0] c_S_IDLE   = 4'd0;
    localparam logic [3:0] c_S_REQ_L  = 4'd1;
    localparam logic [3:0] c_S_WAIT_L = 4'd2;
    localparam logic [3:0] c_S_REQ_W  = 4'd3;
    localparam logic [3:0] c_S_WAIT_W = 4'd4;
    localparam logic [3:0] c_S_MAC    = 4'd5;
    localparam logic [3:0] c_S_WR     = 4'd6;
    localparam logic [3:0] c_S_REQ_N  = 4'd7;
    localparam logic [3:0] c_S_WAIT_N = 4'd8;
    localparam logic [3:0] c_S_FIN    = 4'd9;

    localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(-128);

    logic [3:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [15:0]             r_g;
    logic [7:0]              r_n;
    logic [15:0]             r_iters;
    logic [7:0]              r_modulo;
    logic [7:0]              r_neurons;
    logic                    r_last;
    logic [15:0]             r_offset;
    logic [INPUTS_MAC*8-1:0] r_kernel;
    logic                    r_cfg_err;

    logic                    w_last_grp;
    logic signed [15:0]      w_prod [INPUTS_MAC];
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_bias_ext;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W-1:0] w_relu;
    logic [7:0]              w_sat;
    logic [31:0]             w_cfg_total;
    logic                    w_cfg_bad;

    assign w_last_grp = (r_g == (r_iters - 16'd1));
    assign w_bias_ext = {{(ACC_W-8){bias_FC[7]}}, bias_FC};

    generate
        for (genvar k = 0; k < INPUTS_MAC; k++) begin : g_lane
            localparam logic [7:0] c_LANE = 8'(k);
            logic signed [15:0] w_k;
            logic signed [15:0] w_a;
            logic signed [15:0] w_p;
            assign w_k = {{8{r_kernel[k*8+7]}}, r_kernel[k*8 +: 8]};
            assign w_a = {{8{act_data[k*8+7]}}, act_data[k*8 +: 8]};
            assign w_p = w_k * w_a;
            // lanes past modulo in the final group carry no real input
            assign w_prod[k] = (w_last_grp && (r_modulo != 8'd0) && (c_LANE >= r_modulo))
                               ? 16'sd0 : w_p;
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < INPUTS_MAC; i++) begin
            w_sum = w_sum + {{(ACC_W-16){w_prod[i][15]}}, w_prod[i]};
        end
    end

    always_comb begin
        w_shift = r_acc >>> SHIFT;
        w_relu  = w_shift;
        if (!r_last && (w_shift < 0)) begin
            w_relu = '0;
        end
        if (w_relu > c_SAT_MAX) begin
            w_sat = 8'h7F;
        end else if (w_relu < c_SAT_MIN) begin
            w_sat = 8'h80;
        end else begin
            w_sat = w_relu[7:0];
        end
    end

    assign w_cfg_total = ({16'd0, iters_per_neuron} * 32'(INPUTS_MAC))
                       - ((modulo != 8'd0) ? (32'(INPUTS_MAC) - {24'd0, modulo}) : 32'd0);
    assign w_cfg_bad   = (w_cfg_total != {24'd0, cant_inputs});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_acc     <= '0;
            r_g       <= '0;
            r_n       <= '0;
            r_iters   <= '0;
            r_modulo  <= '0;
            r_neurons <= '0;
            r_last    <= 1'b0;
            r_offset  <= '0;
            r_kernel  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) r_state <= c_S_REQ_L;
                end
                c_S_REQ_L: r_state <= c_S_WAIT_L;
                c_S_WAIT_L: begin
                    if (struct_ready) begin
                        r_iters   <= iters_per_neuron;
                        r_modulo  <= modulo;
                        r_neurons <= cant_neurons;
                        r_last    <= (last != 8'd0);
                        r_offset  <= of_offset;
                        r_acc     <= w_bias_ext;
                        r_n       <= '0;
                        r_g       <= '0;
                        r_cfg_err <= r_cfg_err | w_cfg_bad;
                        if ((cant_neurons == 8'd0) || (iters_per_neuron == 16'd0)) begin
                            r_state <= c_S_FIN;
                        end else begin
                            r_state <= c_S_REQ_W;
                        end
                    end
                end
                c_S_REQ_W: r_state <= c_S_WAIT_W;
                c_S_WAIT_W: begin
                    if (struct_ready) begin
                        r_kernel <= kernel_FC;
                        r_state  <= c_S_MAC;
                    end
                end
                c_S_MAC: begin
                    r_acc <= r_acc + w_sum;
                    r_g   <= r_g + 16'd1;
                    if ((r_g + 16'd1) == r_iters) begin
                        r_state <= c_S_WR;
                    end else begin
                        r_state <= c_S_REQ_W;
                    end
                end
                c_S_WR: begin
                    r_n <= r_n + 8'd1;
                    r_g <= '0;
                    if ((r_n + 8'd1) == r_neurons) begin
                        r_state <= c_S_FIN;
                    end else begin
                        r_state <= c_S_REQ_N;
                    end
                end
                c_S_REQ_N: r_state <= c_S_WAIT_N;
                c_S_WAIT_N: begin
                    if (struct_ready) begin
                        r_acc   <= w_bias_ext;
                        r_state <= c_S_REQ_W;
                    end
                end
                c_S_FIN:  r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    assign next_layer  = (r_state == c_S_REQ_L);
    assign next_neuron = (r_state == c_S_REQ_N);
    assign get_weight  = (r_state == c_S_REQ_W);
    assign act_rd      = (r_state == c_S_WAIT_W) && struct_ready;
    assign act_addr    = act_rd ? (r_g * 16'(INPUTS_MAC)) : 16'd0;
    assign of_wr       = (r_state == c_S_WR);
    assign of_addr     = of_wr ? (r_offset + {8'd0, r_n}) : 16'd0;
    assign of_data     = of_wr ? w_sat : 8'd0;
    assign busy        = (r_state != c_S_IDLE) && (r_state != c_S_FIN);
    assign done        = (r_state == c_S_FIN);
    assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_rn_fc_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rn_fc_ctrl
// Brief    : Scoreboard bench for rn_fc_ctrl; SHIFT=0 and SHIFT=2 run in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rn_fc_ctrl;
    localparam int NL = 6;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [7:0]      cant_inputs = '0, modulo = '0, cant_neurons = '0, last = '0, bias_FC = '0;
    logic [15:0]     iters_per_neuron = '0, of_offset = '0;
    logic [NL*8-1:0] kernel_FC = '0, act_data = '0;
    logic            struct_ready = 1'b0;

    logic        next_layer, next_neuron, get_weight, act_rd, of_wr, busy, done, cfg_err;
    logic [15:0] act_addr, of_addr;
    logic [7:0]  of_data;
    logic        nl2, nn2, gw2, ar2, wr2, busy2, done2, err2;
    logic [15:0] aa2, oa2;
    logic [7:0]  od2;

    rn_fc_ctrl #(.INPUTS_MAC(NL), .SHIFT(0), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .cant_inputs(cant_inputs),
        .iters_per_neuron(iters_per_neuron), .modulo(modulo), .cant_neurons(cant_neurons),
        .last(last), .of_offset(of_offset), .kernel_FC(kernel_FC), .bias_FC(bias_FC),
        .struct_ready(struct_ready), .next_layer(next_layer), .next_neuron(next_neuron),
        .get_weight(get_weight), .act_rd(act_rd), .act_addr(act_addr), .act_data(act_data),
        .of_wr(of_wr), .of_addr(of_addr), .of_data(of_data), .busy(busy), .done(done),
        .cfg_err(cfg_err));

    rn_fc_ctrl #(.INPUTS_MAC(NL), .SHIFT(2), .ACC_W(32)) dut_s2 (
        .clk(clk), .rst(rst), .start(start), .cant_inputs(cant_inputs),
        .iters_per_neuron(iters_per_neuron), .modulo(modulo), .cant_neurons(cant_neurons),
        .last(last), .of_offset(of_offset), .kernel_FC(kernel_FC), .bias_FC(bias_FC),
        .struct_ready(struct_ready), .next_layer(nl2), .next_neuron(nn2),
        .get_weight(gw2), .act_rd(ar2), .act_addr(aa2), .act_data(act_data),
        .of_wr(wr2), .of_addr(oa2), .of_data(od2), .busy(busy2), .done(done2),
        .cfg_err(err2));

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    exp_t q0[$];
    exp_t q2[$];
    int   cnt_nl, cnt_nn, cnt_gw, cnt_ar, cnt_wr, cnt_done;
    bit   lockerr = 1'b0;
    int   stall = 0;
    int   act_limit = 0;
    logic [7:0] act_val = '0;
    logic [7:0] wt [4];
    logic [7:0] bs [4];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d2);
        exp_t e;
        e.addr = a; e.data = d0; q0.push_back(e);
        e.data = d2;             q2.push_back(e);
    endtask

    function automatic logic [63:0] outs();
        return {16'd0, next_layer, next_neuron, get_weight, act_rd, of_wr, busy, done,
                cfg_err, of_addr, of_data, act_addr};
    endfunction

    task automatic clear_counts();
        cnt_nl = 0; cnt_nn = 0; cnt_gw = 0; cnt_ar = 0; cnt_wr = 0; cnt_done = 0;
    endtask

    task automatic setup(input logic [7:0] cin, input logic [15:0] it, input logic [7:0] md,
                         input logic [7:0] nn, input logic [7:0] lst, input logic [15:0] off,
                         input logic [7:0] av, input int st);
        cant_inputs = cin; iters_per_neuron = it; modulo = md; cant_neurons = nn;
        last = lst; of_offset = off; act_val = av; stall = st;
        act_limit = int'(it) * NL;
        clear_counts();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_layer(input string name, input int e_gw, input int e_nn,
                             input logic e_cfg);
        int i;
        pulse_start();
        for (i = 0; i < 3000 && cnt_done == 0; i++) begin
            @(posedge clk); #2;
        end
        if (cnt_done == 0) begin
            bad++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, i);
        end
        repeat (3) @(posedge clk);
        #2;
        check({name, "_done"}, 64'(cnt_done), 64'd1);
        check({name, "_nl"},   64'(cnt_nl),   64'd1);
        check({name, "_gw"},   64'(cnt_gw),   64'(e_gw));
        check({name, "_nn"},   64'(cnt_nn),   64'(e_nn));
        check({name, "_pend"}, 64'(q0.size() + q2.size()), 64'd0);
        check({name, "_cfg"},  64'(cfg_err),  64'(e_cfg));
        check({name, "_busy"}, 64'(busy),     64'd0);
    endtask

    // Parameter-structure responder: struct_ready one cycle, 1+stall cycles after a request.
    initial begin
        int nidx;
        int kind;
        nidx = 0;
        forever begin
            @(posedge clk); #1;
            struct_ready = 1'b0;
            if (!rst && (next_layer || next_neuron || get_weight)) begin
                kind = next_layer ? 0 : (next_neuron ? 1 : 2);
                repeat (1 + stall) @(posedge clk);
                #1;
                if (kind == 0) begin
                    nidx = 0; bias_FC = bs[0];
                end else if (kind == 1) begin
                    nidx = (nidx + 1) % 4; bias_FC = bs[nidx];
                end else begin
                    kernel_FC = {NL{wt[nidx]}};
                end
                struct_ready = 1'b1;
            end
        end
    end

    // Monitor: activation memory, pulse accounting and scoreboard pops.
    initial begin
        bit   p_nl, p_nn, p_gw;
        exp_t e;
        p_nl = 0; p_nn = 0; p_gw = 0;
        forever begin
            @(negedge clk);
            if (act_rd) begin
                cnt_ar++;
                for (int k = 0; k < NL; k++) begin
                    act_data[k*8 +: 8] = ((int'(act_addr) + k) < act_limit) ? act_val : 8'd0;
                end
            end
            if ((int'(next_layer) + int'(next_neuron) + int'(get_weight)) > 1) begin
                bad++;
                $display("FAIL req_overlap: nl=%0b nn=%0b gw=%0b want at most one", next_layer,
                         next_neuron, get_weight);
            end
            if ((next_layer && p_nl) || (next_neuron && p_nn) || (get_weight && p_gw)) begin
                bad++;
                $display("FAIL req_width: request held 2 cycles, want 1");
            end
            p_nl = next_layer; p_nn = next_neuron; p_gw = get_weight;
            cnt_nl += int'(next_layer);
            cnt_nn += int'(next_neuron);
            cnt_gw += int'(get_weight);
            cnt_done += int'(done);
            if (of_wr) begin
                cnt_wr++;
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL wr_s0: unexpected write addr=%0h data=%0h", of_addr, of_data);
                end else begin
                    e = q0.pop_front();
                    if (of_addr !== e.addr || of_data !== e.data) begin
                        bad++;
                        $display("FAIL wr_s0: got addr=%0h data=%0h want addr=%0h data=%0h",
                                 of_addr, of_data, e.addr, e.data);
                    end
                end
            end
            if (wr2) begin
                total++;
                if (q2.size() == 0) begin
                    bad++;
                    $display("FAIL wr_s2: unexpected write addr=%0h data=%0h", oa2, od2);
                end else begin
                    e = q2.pop_front();
                    if (oa2 !== e.addr || od2 !== e.data) begin
                        bad++;
                        $display("FAIL wr_s2: got addr=%0h data=%0h want addr=%0h data=%0h",
                                 oa2, od2, e.addr, e.data);
                    end
                end
            end
            if (busy2 !== busy || done2 !== done || wr2 !== of_wr || gw2 !== get_weight ||
                nl2 !== next_layer || nn2 !== next_neuron || ar2 !== act_rd || aa2 !== act_addr ||
                err2 !== cfg_err)
                lockerr = 1'b1;
        end
    end

    initial begin
        int i;
        for (int k = 0; k < 4; k++) begin wt[k] = 8'd0; bs[k] = 8'd0; end
        clear_counts();
        repeat (3) @(posedge clk);
        #1 check("reset_outs", outs(), 64'd0);
        rst = 1'b0;

        // basic: 3 + 12*1*2 = 27
        wt[0] = 8'd1; bs[0] = 8'd3;
        setup(8'd12, 16'd2, 8'd0, 8'd1, 8'd1, 16'h0040, 8'd2, 0);
        push(16'h0040, 8'd27, 8'd6);
        run_layer("basic", 2, 0, 1'b0);

        // masking: 6*5 + 2*5 = 40
        wt[0] = 8'd1; bs[0] = 8'd0;
        setup(8'd8, 16'd2, 8'd2, 8'd1, 8'd1, 16'h0010, 8'd5, 0);
        push(16'h0010, 8'd40, 8'd10);
        run_layer("mask", 2, 0, 1'b0);

        // ReLU: acc = -50
        wt[0] = 8'd0; bs[0] = 8'hCE;
        setup(8'd6, 16'd1, 8'd0, 8'd1, 8'd0, 16'h0020, 8'd0, 0);
        push(16'h0020, 8'd0, 8'd0);
        run_layer("relu", 1, 0, 1'b0);

        // acc = -24 + 6*(-2*23) = -300
        wt[0] = 8'hFE; bs[0] = 8'hE8;
        setup(8'd6, 16'd1, 8'd0, 8'd1, 8'd1, 16'h0030, 8'd23, 0);
        push(16'h0030, 8'h80, 8'hB5);
        run_layer("satneg", 1, 0, 1'b0);

        // acc = 2 + 6*33 = 200
        wt[0] = 8'd3; bs[0] = 8'd2;
        setup(8'd6, 16'd1, 8'd0, 8'd1, 8'd1, 16'h0031, 8'd11, 0);
        push(16'h0031, 8'd127, 8'd50);
        run_layer("satpos", 1, 0, 1'b0);

        // acc = 4 + 6*16 = 100
        wt[0] = 8'd2; bs[0] = 8'd4;
        setup(8'd6, 16'd1, 8'd0, 8'd1, 8'd1, 16'h0032, 8'd8, 0);
        push(16'h0032, 8'd100, 8'd25);
        run_layer("shift", 1, 0, 1'b0);

        // three neurons, stalled responses, address wrap past 0xFFFF
        wt[0] = 8'd1; wt[1] = 8'd2; wt[2] = 8'd3;
        bs[0] = 8'd0; bs[1] = 8'd10; bs[2] = 8'd20;
        setup(8'd6, 16'd1, 8'd0, 8'd3, 8'd0, 16'hFFFE, 8'd1, 4);
        push(16'hFFFE, 8'd6, 8'd1);
        push(16'hFFFF, 8'd22, 8'd5);
        push(16'h0000, 8'd38, 8'd9);
        run_layer("multi", 3, 2, 1'b0);

        // 2*6 != 13: flagged, layer still completes
        wt[0] = 8'd1; bs[0] = 8'd0;
        setup(8'd13, 16'd2, 8'd0, 8'd1, 8'd1, 16'h0060, 8'd1, 0);
        push(16'h0060, 8'd12, 8'd3);
        run_layer("cfgerr", 2, 0, 1'b1);

        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("cfg_clear", outs(), 64'd0);

        // abort in MAC of neuron 1
        wt[0] = 8'd1; wt[1] = 8'd2; wt[2] = 8'd3;
        bs[0] = 8'd0; bs[1] = 8'd10; bs[2] = 8'd20;
        setup(8'd6, 16'd1, 8'd0, 8'd3, 8'd1, 16'h0050, 8'd1, 0);
        push(16'h0050, 8'd6, 8'd1);
        pulse_start();
        for (i = 0; i < 500 && cnt_ar < 2; i++) begin
            @(posedge clk); #2;
        end
        check("abort_reach", 64'(cnt_ar), 64'd2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_outs", outs(), 64'd0);
        repeat (20) @(posedge clk);
        #2;
        check("abort_wr", 64'(cnt_wr), 64'd1);
        check("abort_done", 64'(cnt_done), 64'd0);
        check("abort_pend", 64'(q0.size() + q2.size()), 64'd0);

        // start during reset is dropped
        clear_counts();
        @(posedge clk); #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("rst_start_nl", 64'(cnt_nl), 64'd0);
        check("rst_start_busy", 64'(busy), 64'd0);

        // clean rerun after the abort
        wt[0] = 8'd1; bs[0] = 8'd3;
        setup(8'd12, 16'd2, 8'd0, 8'd1, 8'd1, 16'h0040, 8'd2, 0);
        push(16'h0040, 8'd27, 8'd6);
        run_layer("rerun", 2, 0, 1'b0);

        check("lockstep", 64'(lockerr), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
`default_nettype wire
